// File: rtl/arb_pkg.sv
// arb_pkg: shared state encodings, owner codes and strobe width for the memory bus arbiter
package arb_pkg;
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_ADDR = 2'd1;
    localparam logic [1:0] ARB_DATA = 2'd2;
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;
    localparam int WSTRB_W = 4;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch, data, memory and perf signals; slave = arbiter view, master = environment view
interface mem_bus_arbiter_if;
    import arb_pkg::*;
    logic i_req;
    logic [31:0] i_addr;
    logic i_cancel;
    logic [31:0] i_rdata;
    logic i_done;
    logic d_req;
    logic d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [WSTRB_W-1:0] d_wstrb;
    logic [31:0] d_rdata;
    logic d_done;
    logic mem_req;
    logic mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [WSTRB_W-1:0] mem_wstrb;
    logic mem_addr_ok;
    logic mem_data_ok;
    logic [31:0] mem_rdata;
    logic [31:0] perf_d_cnt;
    logic [31:0] perf_i_wait;
    modport slave (
        input i_req, i_addr, i_cancel, d_req, d_wr, d_addr, d_wdata, d_wstrb,
        input mem_addr_ok, mem_data_ok, mem_rdata,
        output i_rdata, i_done, d_rdata, d_done,
        output mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb, perf_d_cnt, perf_i_wait
    );
    modport master (
        output i_req, i_addr, i_cancel, d_req, d_wr, d_addr, d_wdata, d_wstrb,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input i_rdata, i_done, d_rdata, d_done,
        input mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb, perf_d_cnt, perf_i_wait
    );
endinterface

// File: rtl/arb_grant_sel.sv
// arb_grant_sel: D-priority grant decision with a saturating I-starvation counter
module arb_grant_sel #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic hold,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;
    logic can_grant;
    assign can_grant = idle && !hold;
    assign grant_i = can_grant && i_req && (starve_cnt == LIMIT || !d_req);
    assign grant_d = can_grant && d_req && !grant_i;
    // count D grants that overtake a waiting fetch; any I grant or idle fetch-free cycle clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_cnt <= 4'd0;
        else if (grant_i || (idle && !i_req)) starve_cnt <= 4'd0;
        else if (grant_d && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between fetch and data sides; ARB_PERF_CNT_EN builds perf counters
module mem_bus_arbiter import arb_pkg::*; #(
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic rst,
    mem_bus_arbiter_if.slave bus
);
    logic [1:0] state;
    logic owner, wr, cancel_flag, turn, grant_i, grant_d, idle, finish;
    logic [31:0] addr, wdata;
    logic [WSTRB_W-1:0] wstrb;
    assign idle = state == ARB_IDLE;
    assign finish = state == ARB_DATA && bus.mem_data_ok;
    // turn marks the done cycle: requesters still hold req for the finished transfer, so no grant then
    arb_grant_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
        .clk(clk), .rst(rst), .idle(idle), .hold(turn),
        .i_req(bus.i_req), .d_req(bus.d_req), .grant_i(grant_i), .grant_d(grant_d)
    );
    assign bus.mem_req = state == ARB_ADDR;
    assign bus.mem_wr = wr;
    assign bus.mem_addr = addr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_wstrb = wstrb;
    // transaction FSM, request field latches and done/rdata steering
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
            owner <= OWNER_I;
            wr <= 1'b0;
            addr <= 32'h0;
            wdata <= 32'h0;
            wstrb <= '0;
            cancel_flag <= 1'b0;
            turn <= 1'b0;
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
            bus.i_rdata <= 32'h0;
            bus.d_rdata <= 32'h0;
        end else begin
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
            turn <= finish;
            if (grant_i || grant_d) begin
                owner <= grant_d ? OWNER_D : OWNER_I;
                wr <= grant_d && bus.d_wr;
                addr <= grant_d ? bus.d_addr : bus.i_addr;
                wdata <= grant_d ? bus.d_wdata : 32'h0;
                wstrb <= (grant_d && bus.d_wr) ? bus.d_wstrb : '0;
                state <= ARB_ADDR;
            end
            if (state == ARB_ADDR && bus.mem_addr_ok) state <= ARB_DATA;
            if (!idle && owner == OWNER_I && bus.i_cancel) cancel_flag <= 1'b1;
            if (finish) begin
                state <= ARB_IDLE;
                cancel_flag <= 1'b0;
                bus.d_done <= owner == OWNER_D;
                bus.i_done <= owner == OWNER_I && !cancel_flag && !bus.i_cancel;
                if (owner == OWNER_D) bus.d_rdata <= bus.mem_rdata;
                else if (!cancel_flag && !bus.i_cancel) bus.i_rdata <= bus.mem_rdata;
            end
        end
    end
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_d, perf_w;
    // D grant count and fetch-waiting cycles, both free-running and wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_d <= 32'h0;
            perf_w <= 32'h0;
        end else begin
            perf_d <= perf_d + 32'(grant_d);
            perf_w <= perf_w + 32'(bus.i_req && (idle ? !grant_i : owner != OWNER_I));
        end
    end
    assign bus.perf_d_cnt = perf_d;
    assign bus.perf_i_wait = perf_w;
`else
    assign bus.perf_d_cnt = 32'h0;
    assign bus.perf_i_wait = 32'h0;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios with a transaction-level grant/completion model and a memory responder
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_bus_arbiter_if bus();
    mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    int stall_cfg = 0;
    logic glog[$];

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // memory responder: addr_ok after stall_cfg waiting cycles, data_ok in the following cycle
    logic acc, busy;
    int st_left;
    logic [31:0] acc_addr;
    initial begin
        bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = 0;
        acc = 0; busy = 0; st_left = 0; acc_addr = 0;
        forever begin
            @(posedge clk); #1;
            bus.mem_addr_ok = 0;
            bus.mem_data_ok = 0;
            if (rst) begin
                acc = 0; busy = 0;
            end else if (acc) begin
                bus.mem_data_ok = 1; bus.mem_rdata = rd_fn(acc_addr); acc = 0;
            end else if (bus.mem_req) begin
                if (!busy) begin busy = 1; st_left = stall_cfg; end
                if (st_left > 0) st_left--;
                else begin bus.mem_addr_ok = 1; acc = 1; busy = 0; acc_addr = bus.mem_addr; end
            end
        end
    end

    // transaction-level model: winner chosen from the requests seen in the grant cycle
    logic m_prev, m_li, m_ld, m_lwr, m_inf, m_own, m_canc, m_pend, m_w;
    logic [31:0] m_lia, m_lda, m_ldw, m_rd, m_ea;
    logic [3:0] m_lds;
    int m_starve = 0, m_dg = 0;
    always @(negedge clk) begin
        if (rst) begin
            m_prev = 0; m_inf = 0; m_pend = 0; m_starve = 0; m_dg = 0; m_li = 0; m_ld = 0;
        end else begin
            chk("both_done", 32'(bus.i_done & bus.d_done), 0);
            chk("i_done", 32'(bus.i_done), 32'(m_pend && !m_own && !m_canc));
            chk("d_done", 32'(bus.d_done), 32'(m_pend && m_own));
            if (m_pend && !m_own && !m_canc) chk("i_rdata", bus.i_rdata, m_rd);
            if (m_pend && m_own) chk("d_rdata", bus.d_rdata, m_rd);
            m_pend = 0;
            if (bus.mem_req && !m_prev) begin
                m_w = !(m_li && m_starve == 4) && m_ld;
                m_starve = (m_w && m_li) ? ((m_starve < 4) ? m_starve + 1 : 4) : 0;
                glog.push_back(m_w);
                m_dg += int'(m_w);
                m_ea = m_w ? m_lda : m_lia;
                chk("grant_wr", 32'(bus.mem_wr), 32'(m_w && m_lwr));
                chk("grant_wstrb", 32'(bus.mem_wstrb), (m_w && m_lwr) ? 32'(m_lds) : 0);
                m_own = m_w; m_canc = 0; m_inf = 1; m_rd = rd_fn(m_ea);
            end
            if (bus.mem_req) begin
                chk("req_addr", bus.mem_addr, m_ea);
                if (m_own && bus.mem_wr) chk("req_wdata", bus.mem_wdata, m_ldw);
            end
            if (m_inf) begin
                if (!m_own && bus.i_cancel) m_canc = 1;
                if (!bus.mem_req && bus.mem_data_ok) begin m_inf = 0; m_pend = 1; end
            end
`ifdef ARB_PERF_CNT_EN
            chk("perf_d_cnt", bus.perf_d_cnt, 32'(m_dg));
`else
            chk("perf_d_cnt", bus.perf_d_cnt, 0);
            chk("perf_i_wait", bus.perf_i_wait, 0);
`endif
            m_prev = bus.mem_req; m_li = bus.i_req; m_ld = bus.d_req; m_lwr = bus.d_wr;
            m_lia = bus.i_addr; m_lda = bus.d_addr; m_ldw = bus.d_wdata; m_lds = bus.d_wstrb;
        end
    end

    // waits for a side's done, dropping whichever request completes along the way
    task automatic wait_done(input logic dside, output int lat, output int reqc, output int rises,
                             output logic [31:0] a0, output logic [3:0] s0, output logic w0);
        logic p, got, di, dd;
        p = 0; got = 0; di = 0; dd = 0;
        lat = 0; reqc = 0; rises = 0; a0 = 0; s0 = 0; w0 = 0;
        for (int n = 0; n < 80 && !got; n++) begin
            @(posedge clk); #1;
            if (di) bus.i_req = 0;
            if (dd) bus.d_req = 0;
            di = 0; dd = 0;
            lat++;
            @(negedge clk);
            if (bus.mem_req) begin
                reqc++;
                if (!p) begin
                    rises++;
                    if (rises == 1) begin a0 = bus.mem_addr; s0 = bus.mem_wstrb; w0 = bus.mem_wr; end
                end
            end
            p = bus.mem_req;
            di = bus.i_done; dd = bus.d_done;
            got = dside ? bus.d_done : bus.i_done;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL wait_done side=%0d: no done within 80 cycles", dside);
        end
        @(posedge clk); #1;
        if (di) bus.i_req = 0;
        if (dd) bus.d_req = 0;
    endtask

    int lat, reqc, rises, base, icnt;
    logic [31:0] a0;
    logic [3:0] s0;
    logic w0, p;
    logic [5:0] pat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req = 0; bus.i_addr = 0; bus.i_cancel = 0;
        bus.d_req = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_i_done", 32'(bus.i_done), 0);
        chk("rst_d_done", 32'(bus.d_done), 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_perf_i_wait", bus.perf_i_wait, 0);
        rst = 0;
        @(posedge clk); #1;
        // D-only load
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h100;
        wait_done(1, lat, reqc, rises, a0, s0, w0);
        chk("t1_latency", lat, 3);
        chk("t1_mem_addr", a0, 32'h100);
        chk("t1_mem_wstrb", 32'(s0), 0);
        chk("t1_d_rdata", bus.d_rdata, 32'hDEADBEEF);
        chk("t1_rises", rises, 1);
        // contention: D store wins, fetch follows
        base = glog.size();
        bus.i_req = 1; bus.i_addr = 32'h200;
        bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 32'h300; bus.d_wdata = 32'hCAFEF00D; bus.d_wstrb = 4'b0011;
        wait_done(1, lat, reqc, rises, a0, s0, w0);
        chk("t2_wstrb", 32'(s0), 32'h3);
        chk("t2_wr", 32'(w0), 1);
        chk("t2_addr", a0, 32'h300);
        wait_done(0, lat, reqc, rises, a0, s0, w0);
        chk("t2_i_rdata", bus.i_rdata, 32'h0200FDFF);
        chk("t2_grants", glog.size() - base, 2);
        chk("t2_first_d", 32'(glog[base]), 1);
        chk("t2_then_i", 32'(glog[base+1]), 0);
        bus.d_wr = 0; bus.d_wstrb = 0;
        // starvation: fetch held, D re-raised after every completion
        base = glog.size();
        bus.i_req = 1; bus.i_addr = 32'h600;
        for (int k = 0; k < 5; k++) begin
            bus.d_req = 1; bus.d_addr = 32'h700 + 32'(k * 4);
            wait_done(1, lat, reqc, rises, a0, s0, w0);
            if (k == 3) chk("t3_starve_full", 32'(dut.u_sel.starve_cnt), 4);
        end
        pat = 6'b101111;
        chk("t3_grants", glog.size() - base, 6);
        for (int j = 0; j < 6; j++) chk("t3_order", 32'(glog[base+j]), 32'(pat[j]));
        chk("t3_starve_clear", 32'(dut.u_sel.starve_cnt), 0);
        // cancel during DATA
        bus.i_req = 1; bus.i_addr = 32'h400;
        rises = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.mem_req) begin rises = 1; break; end
        end
        @(posedge clk); #1;
        bus.i_cancel = 1; bus.i_req = 0;
        @(posedge clk); #1;
        bus.i_cancel = 0;
        icnt = 0; p = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.i_done) icnt++;
            if (bus.mem_req && !p) rises++;
            p = bus.mem_req;
        end
        chk("t4_one_req", rises, 1);
        chk("t4_no_i_done", icnt, 0);
        chk("t4_rdata_held", bus.i_rdata, 32'h0600F9FF);
        @(posedge clk); #1;
        bus.i_req = 1; bus.i_addr = 32'h500;
        wait_done(0, lat, reqc, rises, a0, s0, w0);
        chk("t4_next_rdata", bus.i_rdata, 32'h0500FAFF);
        chk("t4_next_latency", lat, 3);
        // backpressure: addr_ok withheld for 5 cycles
        stall_cfg = 5;
        bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 32'h800; bus.d_wdata = 32'h12345678; bus.d_wstrb = 4'b1111;
        wait_done(1, lat, reqc, rises, a0, s0, w0);
        chk("t5_req_cycles", reqc, 6);
        chk("t5_rises", rises, 1);
        chk("t5_latency", lat, 8);
        stall_cfg = 10;
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h900; bus.d_wstrb = 0;
        // reset while the address phase is stalled
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.mem_req) break;
        end
        #1 rst = 1;
        #1;
        chk("t6_mem_req", 32'(bus.mem_req), 0);
        chk("t6_i_done", 32'(bus.i_done), 0);
        chk("t6_d_done", 32'(bus.d_done), 0);
        chk("t6_perf_d", bus.perf_d_cnt, 0);
        chk("t6_perf_w", bus.perf_i_wait, 0);
        bus.d_req = 0;
        stall_cfg = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        bus.d_req = 1; bus.d_addr = 32'h100;
        wait_done(1, lat, reqc, rises, a0, s0, w0);
        chk("t7_latency", lat, 3);
        chk("t7_d_rdata", bus.d_rdata, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
